// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Function : shares the single data-memory port between the CPU MEM stage and
//            a DMA/debug requester; CPU priority with DMA anti-starvation.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU requester
  input  logic                  cpu_req,
  input  logic                  cpu_rw,
  input  logic [1:0]            cpu_type,
  input  logic                  cpu_sign,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic                  cpu_stall,
  // DMA / debug requester
  input  logic                  dma_req,
  input  logic                  dma_rw,
  input  logic [1:0]            dma_type,
  input  logic                  dma_sign,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_done,
  output logic                  dma_err,
  // Data memory port (TYPE carries the memory access type)
  output logic [ADDR_WIDTH-1:0] MADD,
  output logic [DATA_WIDTH-1:0] MDATA,
  output logic [1:0]            TYPE,
  output logic                  SignM,
  output logic                  RW,
  input  logic [DATA_WIDTH-1:0] MDOUT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACC_CPU = 2'd1;
  localparam logic [1:0] S_ACC_DMA = 2'd2;

  localparam logic [3:0]            STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR_A  = ADDR_WIDTH'(32'h15);
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR_B  = ADDR_WIDTH'(32'h16);

  logic [1:0]            state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] madd_q, madd_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [1:0]            type_q, type_d;
  logic                  sign_q, sign_d;
  logic                  rw_q, rw_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  cpu_err_q, cpu_err_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                  dma_done_q, dma_done_d;
  logic                  dma_err_q, dma_err_d;

  logic w_dma_win;
  logic w_cpu_win;
  logic w_dma_ill;
  logic w_cpu_ill;
  logic w_acc_read;

  always_comb begin
    w_dma_win = dma_req & (~cpu_req | (starve_q == STARVE_MAX));
    w_cpu_win = cpu_req & ~w_dma_win;
    // The IO window is reserved for the CPU; DMA may not touch it.
    w_dma_ill = (dma_type == 2'b11) | (dma_addr == IO_ADDR_A) | (dma_addr == IO_ADDR_B);
    w_cpu_ill = (cpu_type == 2'b11);
    w_acc_read = ~ill_q & ~rw_q;
  end

  // Arbitration and port-register load; runs on every edge since accesses last one cycle.
  always_comb begin
    state_d = S_IDLE;
    madd_d  = madd_q;
    mdata_d = mdata_q;
    sign_d  = sign_q;
    type_d  = 2'b00;
    rw_d    = 1'b0;
    ill_d   = 1'b0;
    if (w_dma_win) begin
      state_d = S_ACC_DMA;
      madd_d  = dma_addr;
      mdata_d = dma_wdata;
      type_d  = dma_type;
      sign_d  = dma_sign;
      ill_d   = w_dma_ill;
      rw_d    = dma_rw & ~w_dma_ill;
    end else if (w_cpu_win) begin
      state_d = S_ACC_CPU;
      madd_d  = cpu_addr;
      mdata_d = cpu_wdata;
      type_d  = cpu_type;
      sign_d  = cpu_sign;
      ill_d   = w_cpu_ill;
      rw_d    = cpu_rw & ~w_cpu_ill;
    end

    if (w_cpu_win & dma_req) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
  end

  // Completion of the access that occupied the port during the cycle now ending.
  always_comb begin
    cpu_done_d  = (state_q == S_ACC_CPU);
    cpu_err_d   = cpu_done_d & ill_q;
    cpu_rdata_d = (cpu_done_d & w_acc_read) ? MDOUT : cpu_rdata_q;
    dma_done_d  = (state_q == S_ACC_DMA);
    dma_err_d   = dma_done_d & ill_q;
    dma_rdata_d = (dma_done_d & w_acc_read) ? MDOUT : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      madd_q      <= '0;
      mdata_q     <= '0;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      rw_q        <= 1'b0;
      ill_q       <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_rdata_q <= '0;
      dma_done_q  <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      madd_q      <= madd_d;
      mdata_q     <= mdata_d;
      type_q      <= type_d;
      sign_q      <= sign_d;
      rw_q        <= rw_d;
      ill_q       <= ill_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      dma_rdata_q <= dma_rdata_d;
      dma_done_q  <= dma_done_d;
      dma_err_q   <= dma_err_d;
    end
  end

  // RW comes straight from a flop so the negedge write strobe is glitch-free.
  assign MADD      = madd_q;
  assign MDATA     = mdata_q;
  assign TYPE      = type_q;
  assign SignM     = sign_q;
  assign RW        = rw_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_done  = dma_done_q;
  assign dma_err   = dma_err_q;

endmodule
`default_nettype wire
